// File: rtl/jk_cnt_pkg.sv
// Shared definitions for the JK-flop based counters.
//   JK_* constants : {J,K} encodings understood by jk_ff_sr
//   jk_drive(q,nxt): {J,K} pair that moves a flop from q to nxt in one edge
package jk_cnt_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Forced drive: set when going 0->1, reset when going 1->0, otherwise hold.
    function automatic logic [1:0] jk_drive(input logic q, input logic nxt);
        return {nxt & ~q, ~nxt & q};
    endfunction

endpackage

// File: rtl/jk_ff_sr.sv
// JK flip-flop with synchronous active-low reset to RST_VAL.
// Ports:
//   clk   in  rising-edge clock
//   rst_n in  synchronous reset, active low (q <= RST_VAL)
//   j, k  in  JK inputs
//   q     out flop output
//   qb    out inverted flop output
module jk_ff_sr
    import jk_cnt_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else begin
            case ({j, k})
                JK_SET:    q <= 1'b1;
                JK_RESET:  q <= 1'b0;
                JK_TOGGLE: q <= ~q;
                default:   q <= q;
            endcase
        end
    end

    assign qb = ~q;

endmodule

// File: rtl/jk_sync_down_counter.sv
// Synchronous modulo-MOD down counter built from JK flip-flops.
// Counts MOD-1 down to 0 and wraps; borrow can drive the en of a more
// significant stage.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  synchronous reset, active low (count <= MOD-1)
//   en     in  count enable (decrement)
//   load   in  parallel load strobe (din, clamped to MOD-1)
//   din    in  parallel load value
//   count  out registered count (flop Q outputs)
//   zero   out count == 0
//   borrow out en & zero & ~load; high in the cycle that wraps
module jk_sync_down_counter
    import jk_cnt_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             borrow
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

    logic [WIDTH-1:0] qb;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] low_zero;
    logic             forced;
    logic             toggle;

    assign zero   = &qb;
    assign borrow = en & zero & ~load;

    always_comb begin
        // low_zero[i]: every bit below i is 0, so bit i toggles on a decrement.
        low_zero[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            low_zero[i] = low_zero[i-1] & qb[i-1];
        end
    end

    always_comb begin
        nxt    = count;
        forced = 1'b0;
        toggle = 1'b0;
        if (!rst_n) begin
            nxt    = MAX_VAL;
            forced = 1'b1;
        end else if (load) begin
            nxt    = ({1'b0, din} < MOD_EXT) ? din : MAX_VAL;
            forced = 1'b1;
        end else if (en) begin
            if (zero) begin
                // Explicit wrap; for MOD == 2**WIDTH it matches the natural rollover.
                nxt    = MAX_VAL;
                forced = 1'b1;
            end else begin
                // Plain binary decrement, also for out-of-range states >= MOD.
                toggle = 1'b1;
            end
        end
    end

    always_comb begin
        j = '0;
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (forced) begin
                {j[i], k[i]} = jk_drive(count[i], nxt[i]);
            end else if (toggle && low_zero[i]) begin
                {j[i], k[i]} = JK_TOGGLE;
            end else begin
                {j[i], k[i]} = JK_HOLD;
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        jk_ff_sr #(
            .RST_VAL(MAX_VAL[g])
        ) u_ff (
            .clk  (clk),
            .rst_n(rst_n),
            .j    (j[g]),
            .k    (k[g]),
            .q    (count[g]),
            .qb   (qb[g])
        );
    end

endmodule

// File: tb/tb_jk_sync_down_counter.sv
module tb_jk_sync_down_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: WIDTH=4, MOD=10
    logic       rst_n, en, load;
    logic [3:0] din;
    logic [3:0] count;
    logic       zero, borrow;

    jk_sync_down_counter #(.WIDTH(4), .MOD(10)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .din(din),
        .count(count), .zero(zero), .borrow(borrow)
    );

    // Cascade: two MOD=16 stages, low borrow drives high en
    logic       c_rst_n, c_en;
    logic [3:0] c_lo_count, c_hi_count;
    logic       c_lo_zero, c_hi_zero, c_lo_borrow, c_hi_borrow;

    jk_sync_down_counter #(.WIDTH(4), .MOD(16)) u_lo (
        .clk(clk), .rst_n(c_rst_n), .en(c_en), .load(1'b0), .din(4'd0),
        .count(c_lo_count), .zero(c_lo_zero), .borrow(c_lo_borrow)
    );

    jk_sync_down_counter #(.WIDTH(4), .MOD(16)) u_hi (
        .clk(clk), .rst_n(c_rst_n), .en(c_lo_borrow), .load(1'b0), .din(4'd0),
        .count(c_hi_count), .zero(c_hi_zero), .borrow(c_hi_borrow)
    );

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       load;
        logic [3:0] din;
        logic       exp_borrow;  // before the edge
        logic [3:0] exp_count;   // after the edge
        logic       exp_zero;    // after the edge
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add(input logic r, input logic e, input logic l, input logic [3:0] d,
                       input logic eb, input logic [3:0] ec, input logic ez);
        vec_t v;
        v.rst_n = r; v.en = e; v.load = l; v.din = d;
        v.exp_borrow = eb; v.exp_count = ec; v.exp_zero = ez;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    int pulses;

    initial begin
        rst_n = 1'b1; en = 1'b0; load = 1'b0; din = 4'd0;
        c_rst_n = 1'b1; c_en = 1'b0;

        //   rst en ld din  borrow count zero
        add(0, 0, 0, 4'd0,  0, 4'd9, 0);   // reset, 2 edges
        add(0, 0, 0, 4'd0,  0, 4'd9, 0);
        add(1, 1, 0, 4'd0,  0, 4'd8, 0);   // countdown
        add(1, 1, 0, 4'd0,  0, 4'd7, 0);
        add(1, 1, 0, 4'd0,  0, 4'd6, 0);
        add(1, 1, 0, 4'd0,  0, 4'd5, 0);
        add(1, 1, 0, 4'd0,  0, 4'd4, 0);
        add(1, 1, 0, 4'd0,  0, 4'd3, 0);
        add(1, 1, 0, 4'd0,  0, 4'd2, 0);
        add(1, 1, 0, 4'd0,  0, 4'd1, 0);
        add(1, 1, 0, 4'd0,  0, 4'd0, 1);
        add(1, 1, 0, 4'd0,  1, 4'd9, 0);   // wrap, borrow in the zero cycle
        add(1, 1, 0, 4'd0,  0, 4'd8, 0);
        add(1, 0, 1, 4'd5,  0, 4'd5, 0);   // load
        add(1, 1, 1, 4'd3,  0, 4'd3, 0);   // load wins over en
        add(1, 1, 1, 4'd12, 0, 4'd9, 0);   // clamp
        add(1, 0, 1, 4'd10, 0, 4'd9, 0);   // clamp at din == MOD
        add(1, 0, 1, 4'd0,  0, 4'd0, 1);
        add(1, 0, 0, 4'd0,  0, 4'd0, 1);   // hold at zero, no borrow
        add(1, 1, 1, 4'd6,  0, 4'd6, 0);   // load at zero suppresses borrow
        add(1, 0, 1, 4'd4,  0, 4'd4, 0);
        add(1, 0, 0, 4'd0,  0, 4'd4, 0);   // hold x5
        add(1, 0, 0, 4'd0,  0, 4'd4, 0);
        add(1, 0, 0, 4'd0,  0, 4'd4, 0);
        add(1, 0, 0, 4'd0,  0, 4'd4, 0);
        add(1, 0, 0, 4'd0,  0, 4'd4, 0);
        add(1, 0, 1, 4'd2,  0, 4'd2, 0);
        add(0, 1, 1, 4'd7,  0, 4'd9, 0);   // reset beats load and en
        add(1, 1, 0, 4'd0,  0, 4'd8, 0);
        add(1, 0, 1, 4'd0,  0, 4'd0, 1);
        add(1, 1, 0, 4'd15, 1, 4'd9, 0);   // wrap again, din ignored
        add(1, 1, 0, 4'd0,  0, 4'd8, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; en = vecs[i].en;
            load  = vecs[i].load;  din = vecs[i].din;
            #1;
            check($sformatf("v%0d_borrow", i), int'(borrow), int'(vecs[i].exp_borrow));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_count", i), int'(count), int'(vecs[i].exp_count));
            check($sformatf("v%0d_zero", i), int'(zero), int'(vecs[i].exp_zero));
        end

        // Cascade: 256 enables from 0xFF return to 0xFF, upper borrow once
        @(negedge clk);
        en = 1'b0; load = 1'b0;
        c_rst_n = 1'b0; c_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        c_rst_n = 1'b1;
        check("casc_reset", int'({c_hi_count, c_lo_count}), 8'hFF);
        c_en   = 1'b1;
        pulses = 0;
        for (int s = 1; s <= 256; s++) begin
            #1;
            if (c_hi_borrow) pulses++;
            @(posedge clk);
            #1;
            if (s == 1)   check("casc_step1",  int'({c_hi_count, c_lo_count}), 8'hFE);
            if (s == 16)  check("casc_step16", int'({c_hi_count, c_lo_count}), 8'hEF);
            if (s == 255) check("casc_step255", int'({c_hi_count, c_lo_count}), 8'h00);
            @(negedge clk);
        end
        c_en = 1'b0;
        check("casc_final", int'({c_hi_count, c_lo_count}), 8'hFF);
        check("casc_pulses", pulses, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
